mc_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the multi-cycle ARM core. It executes MUL, UMULL, SMULL and, optionally, UDIV over several cycles, producing low and high result words; the high word feeds the RegWriteHi write path. The controller starts an operation, stalls its FSM on busy, and writes results when done pulses.

---
 rtl/mc_muldiv_unit_if.sv | 25 ++
 rtl/mc_muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_mc_muldiv_unit.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_muldiv_unit_if.sv
// Operand/result bundle between the core controller (master) and the
// iterative multiply/divide unit (slave).
interface mc_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             div_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, result_lo, result_hi, div_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result_lo, result_hi, div_zero
   );
endinterface

// File: rtl/mc_muldiv_unit.sv
// Iterative radix-2 MUL/UMULL/SMULL unit with optional restoring UDIV.
// UDIV datapath is built only when MULDIV_UDIV_EN is defined.
module mc_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic             clk,
   input logic             reset,
   mc_muldiv_unit_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   // IDLE wait for start | CALC one step per cycle | FIX sign/results | DONE pulse
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [CNT_W-1:0]   r_cnt;
   logic [1:0]         r_op;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_neg;
   logic [WIDTH-1:0]   r_res_lo;
   logic [WIDTH-1:0]   r_res_hi;
   logic               r_div_zero;

   logic               w_accept;
   logic               w_skip;
   logic               w_last;
   logic               w_busy;
   logic               w_done;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_add;
   logic [WIDTH-1:0]   w_step_hi;
   logic [WIDTH-1:0]   w_step_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_neg;
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;
`ifdef MULDIV_UDIV_EN
   logic               r_dz;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH-1:0]   w_rem_diff;
   logic               w_ge;
`endif

   assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_UDIV_EN
   assign w_skip = (bus.op == 2'b11) && (bus.b == '0);
`else
   assign w_skip = (bus.op == 2'b11);
`endif

   // SMULL runs on magnitudes; the most-negative value maps to 2^(WIDTH-1) unchanged
   assign w_a_mag = (bus.op == 2'b10 && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign w_b_mag = (bus.op == 2'b10 && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: w_next = w_accept ? (w_skip ? S_FIX : S_CALC) : S_IDLE;
         S_CALC:         if (w_last) w_next = S_FIX;
         S_FIX:          w_next = S_DONE;
         default:        w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_CALC, S_FIX: w_busy = 1'b1;
         S_DONE:        w_done = 1'b1;
         default:       ;
      endcase
   end

   assign w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);

`ifdef MULDIV_UDIV_EN
   assign w_rem_sh   = {r_hi, r_lo[WIDTH-1]};
   assign w_ge       = (w_rem_sh >= {1'b0, r_mcand});
   assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_mcand;
`endif

   always_comb begin
      w_step_hi = w_add[WIDTH:1];
      w_step_lo = {w_add[0], r_lo[WIDTH-1:1]};
`ifdef MULDIV_UDIV_EN
      if (r_op == 2'b11) begin
         w_step_hi = w_ge ? w_rem_diff : w_rem_sh[WIDTH-1:0];
         w_step_lo = {r_lo[WIDTH-2:0], w_ge};
      end
`endif
   end

   assign w_prod     = {r_hi, r_lo};
   assign w_prod_neg = -w_prod;

   always_comb begin
      {w_fix_hi, w_fix_lo} = w_prod;
      case (r_op)
         2'b10: if (r_neg) {w_fix_hi, w_fix_lo} = w_prod_neg;
         2'b11: begin
`ifdef MULDIV_UDIV_EN
            if (r_dz) begin
               w_fix_lo = '1;
               w_fix_hi = r_lo;
            end
`else
            w_fix_lo = '0;
            w_fix_hi = '0;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= '0;
         r_op       <= '0;
         r_mcand    <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_neg      <= 1'b0;
         r_res_lo   <= '0;
         r_res_hi   <= '0;
         r_div_zero <= 1'b0;
`ifdef MULDIV_UDIV_EN
         r_dz       <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_op       <= bus.op;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_div_zero <= 1'b0;
            r_neg      <= (bus.op == 2'b10) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`ifdef MULDIV_UDIV_EN
            r_dz       <= (bus.b == '0);
            r_lo       <= (bus.op == 2'b11) ? bus.a : w_b_mag;
            r_mcand    <= (bus.op == 2'b11) ? bus.b : w_a_mag;
`else
            r_lo       <= w_b_mag;
            r_mcand    <= w_a_mag;
`endif
         end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
         end
         if (r_state == S_FIX) begin
            r_res_lo   <= w_fix_lo;
            r_res_hi   <= w_fix_hi;
`ifdef MULDIV_UDIV_EN
            r_div_zero <= (r_op == 2'b11) && r_dz;
`else
            r_div_zero <= 1'b0;
`endif
         end
      end
   end

   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.result_lo = r_res_lo;
   assign bus.result_hi = r_res_hi;
   assign bus.div_zero  = r_div_zero;
endmodule

// File: tb/tb_mc_muldiv_unit.sv
// Self-checking bench for mc_muldiv_unit: arithmetic reference model,
// latency/busy checks, start-ignore, back-to-back and reset-abort scenarios.
module tb_mc_muldiv_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   mc_muldiv_unit_if #(.WIDTH(W)) bus ();
   mc_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   // Reference: plain 64-bit arithmetic; lat counts cycles from the start cycle to done.
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] lo, output logic [31:0] hi,
                                 output logic dz, output int lat);
      logic [63:0] p;
      longint      sp;
      lat = 34;
      dz  = 1'b0;
      lo  = '0;
      hi  = '0;
      case (op)
         2'b10: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            p  = sp;
            {hi, lo} = p;
         end
         2'b11: begin
`ifdef MULDIV_UDIV_EN
            if (b == 0) begin
               lo = 32'hFFFF_FFFF; hi = a; dz = 1'b1; lat = 2;
            end else begin
               lo = a / b; hi = a % b;
            end
`else
            lat = 2;
`endif
         end
         default: begin
            p = {32'b0, a} * {32'b0, b};
            {hi, lo} = p;
         end
      endcase
   endfunction

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt, output bit tmo);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom_range(0, 3));
      lat = 0; busy_cnt = 0; tmo = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         lat++;
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            tmo = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      n_tests++;
      if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags busy/done/dz got %b%b%b want 000", bus.busy, bus.done, bus.div_zero);
      end
      n_tests++;
      if ({bus.result_hi, bus.result_lo} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_results got %h_%h want 0", bus.result_hi, bus.result_lo);
      end
   endtask

   task automatic test_directed();
      logic [1:0]  ops [6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
      logic [31:0] as  [6] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'd100, 32'h1234};
      logic [31:0] bs  [6] = '{32'd6, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd7, 32'd0};
      logic [31:0] elo, ehi;
      logic        edz;
      int          elat, lat, bc;
      bit          tmo;
      for (int i = 0; i < 6; i++) begin
         model(ops[i], as[i], bs[i], elo, ehi, edz, elat);
         do_op(ops[i], as[i], bs[i], lat, bc, tmo);
         n_tests++;
         if (tmo || lat !== elat) begin
            n_fail++;
            $display("FAIL directed%0d latency got %0d (timeout=%0d) want %0d", i, lat, tmo, elat);
         end
         n_tests++;
         if (bc !== elat - 1) begin
            n_fail++;
            $display("FAIL directed%0d busy_cycles got %0d want %0d", i, bc, elat - 1);
         end
         n_tests++;
         if ({bus.result_hi, bus.result_lo, bus.div_zero} !== {ehi, elo, edz}) begin
            n_fail++;
            $display("FAIL directed%0d result got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                     i, bus.result_hi, bus.result_lo, bus.div_zero, ehi, elo, edz);
         end
      end
      // results hold and done stays a single pulse
      repeat (3) @(negedge clk);
      n_tests++;
      if ({bus.done, bus.busy, bus.result_hi, bus.result_lo, bus.div_zero} !== {1'b0, 1'b0, ehi, elo, edz}) begin
         n_fail++;
         $display("FAIL hold got done=%b busy=%b hi=%h lo=%h dz=%b want 0 0 %h %h %b",
                  bus.done, bus.busy, bus.result_hi, bus.result_lo, bus.div_zero, ehi, elo, edz);
      end
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] sp [5] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
      if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b, elo, ehi;
      logic        edz;
      int          elat, lat, bc;
      bit          tmo;
      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = pick_operand();
         b  = pick_operand();
         model(op, a, b, elo, ehi, edz, elat);
         do_op(op, a, b, lat, bc, tmo);
         n_tests++;
         if (tmo || lat !== elat || {bus.result_hi, bus.result_lo, bus.div_zero} !== {ehi, elo, edz}) begin
            n_fail++;
            $display("FAIL random%0d op=%0d a=%h b=%h got lat=%0d hi=%h lo=%h dz=%b want lat=%0d hi=%h lo=%h dz=%b",
                     i, op, a, b, lat, bus.result_hi, bus.result_lo, bus.div_zero, elat, ehi, elo, edz);
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [31:0] elo, ehi;
      logic        edz;
      int          elat, lat;
      bit          seen;
      model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, elo, ehi, edz, elat);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'hDEAD_BEEF; bus.b = 32'h0000_0003;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 5; seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         lat++;
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!seen || lat !== elat) begin
         n_fail++;
         $display("FAIL ignore_start latency got %0d (seen=%0d) want %0d", lat, seen, elat);
      end
      n_tests++;
      if ({bus.result_hi, bus.result_lo} !== {ehi, elo}) begin
         n_fail++;
         $display("FAIL ignore_start result got %h_%h want %h_%h", bus.result_hi, bus.result_lo, ehi, elo);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, b1, a2, b2, elo, ehi;
      logic        edz;
      int          elat, lat;
      bit          seen;
      a1 = $urandom; b1 = $urandom; a2 = $urandom | 32'h1; b2 = $urandom | 32'h1;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b10; bus.a = a1; bus.b = b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      model(2'b10, a1, b1, elo, ehi, edz, elat);
      n_tests++;
      if (!seen || {bus.result_hi, bus.result_lo} !== {ehi, elo}) begin
         n_fail++;
         $display("FAIL b2b_first seen=%0d got %h_%h want %h_%h", seen, bus.result_hi, bus.result_lo, ehi, elo);
      end
      bus.op = 2'b01; bus.a = a2; bus.b = b2;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 0; seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            n_tests++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_restart busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
            end
         end
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      model(2'b01, a2, b2, elo, ehi, edz, elat);
      n_tests++;
      if (!seen || lat !== 34 || {bus.result_hi, bus.result_lo} !== {ehi, elo}) begin
         n_fail++;
         $display("FAIL b2b_second seen=%0d lat=%0d got %h_%h want lat=34 %h_%h",
                  seen, lat, bus.result_hi, bus.result_lo, ehi, elo);
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] elo, ehi;
      logic        edz;
      int          elat, lat, bc, dones;
      bit          tmo;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h0001_0003; bus.b = 32'h0000_0101;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_tests++;
      if ({bus.busy, bus.done, bus.div_zero, bus.result_hi, bus.result_lo} !== 67'h0) begin
         n_fail++;
         $display("FAIL abort_clear busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                  bus.busy, bus.done, bus.div_zero, bus.result_hi, bus.result_lo);
      end
      dones = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) dones++;
      end
      n_tests++;
      if (dones !== 0) begin
         n_fail++;
         $display("FAIL abort_no_done got %0d done/busy cycles want 0", dones);
      end
      model(2'b10, 32'hFFFF_FF00, 32'h0000_1234, elo, ehi, edz, elat);
      do_op(2'b10, 32'hFFFF_FF00, 32'h0000_1234, lat, bc, tmo);
      n_tests++;
      if (tmo || lat !== elat || {bus.result_hi, bus.result_lo} !== {ehi, elo}) begin
         n_fail++;
         $display("FAIL abort_recover lat=%0d got %h_%h want lat=%0d %h_%h",
                  lat, bus.result_hi, bus.result_lo, elat, ehi, elo);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
